// File: rtl/sys_mem_test_master_if.sv
// sys_mem_test_master_if: Avalon-MM 64-bit word bus between the test master and memory
interface sys_mem_test_master_if;
    logic [12:0] avm_address;
    logic [7:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [63:0] avm_writedata;
    logic        avm_waitrequest;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    modport master (
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );
    modport slave (
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/sys_mem_test_master.sv
// sys_mem_test_master: fills a memory window with a seeded pattern and checks it back over Avalon-MM
module sys_mem_test_master #(
    parameter int MAX_PENDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [12:0]                  base_addr,
    input  logic [13:0]                  length,
    input  logic [31:0]                  seed,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  err_count,
    output logic [12:0]                  first_err_addr,
    sys_mem_test_master_if.master        avm
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_mode;
    logic [12:0] r_base;
    logic [13:0] r_n;
    logic [13:0] r_idx;
    logic [13:0] r_rsp;
    logic [31:0] r_seed;
    logic [3:0]  r_pending;

    logic [13:0] w_n;
    logic        w_start;
    logic        w_acc_wr;
    logic        w_acc_rd;
    logic        w_last;
    logic        w_rsp;
    logic        w_miss;
    logic [31:0] w_s_wr;
    logic [31:0] w_s_rd;

    // The window never exceeds the 8192-word address space
    assign w_n      = (length > 14'd8192) ? 14'd8192 : length;
    assign w_start  = start && (r_state == IDLE);
    assign w_acc_wr = avm.avm_write && !avm.avm_waitrequest;
    assign w_acc_rd = avm.avm_read && !avm.avm_waitrequest;
    assign w_last   = (r_idx == r_n - 14'd1);
    // Responses only count while a check pass has reads outstanding
    assign w_rsp    = avm.avm_readdatavalid && (r_state == READ || r_state == DRAIN) && (r_pending != 4'd0);
    assign w_s_wr   = r_seed + {18'd0, r_idx};
    assign w_s_rd   = r_seed + {18'd0, r_rsp};
    assign w_miss   = w_rsp && (avm.avm_readdata != {w_s_rd, ~w_s_rd});

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: write pass, then read pass, then wait for the tail of responses
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (w_n == 14'd0 || mode == 2'b00) ? FINISH : (mode[0] ? WRITE : READ);
            WRITE:   if (w_acc_wr && w_last) w_next = r_mode[1] ? READ : FINISH;
            READ:    if (w_acc_rd && w_last) w_next = DRAIN;
            DRAIN:   if (r_pending == 4'd0) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs: commands derive from registered index, so they hold steady through stalls
    always_comb begin
        busy               = r_state != IDLE;
        done               = r_state == FINISH;
        avm.avm_write      = r_state == WRITE;
        avm.avm_read       = (r_state == READ) && (r_pending < 4'(MAX_PENDING));
        avm.avm_address    = (r_state == WRITE || r_state == READ) ? r_base + r_idx[12:0] : 13'd0;
        avm.avm_writedata  = (r_state == WRITE) ? {w_s_wr, ~w_s_wr} : 64'd0;
        avm.avm_byteenable = 8'hFF;
    end

    // Command capture, issue/response counters and error tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode         <= 2'd0;
            r_base         <= 13'd0;
            r_n            <= 14'd0;
            r_seed         <= 32'd0;
            r_idx          <= 14'd0;
            r_rsp          <= 14'd0;
            r_pending      <= 4'd0;
            err_count      <= 16'd0;
            first_err_addr <= 13'd0;
        end else if (w_start) begin
            r_mode         <= mode;
            r_base         <= base_addr;
            r_n            <= w_n;
            r_seed         <= seed;
            r_idx          <= 14'd0;
            r_rsp          <= 14'd0;
            r_pending      <= 4'd0;
            err_count      <= 16'd0;
            first_err_addr <= 13'd0;
        end else begin
            if (w_acc_wr)      r_idx <= w_last ? 14'd0 : r_idx + 14'd1;
            else if (w_acc_rd) r_idx <= r_idx + 14'd1;
            r_pending <= r_pending + {3'd0, w_acc_rd} - {3'd0, w_rsp};
            if (w_rsp) r_rsp <= r_rsp + 14'd1;
            if (w_miss) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0)    first_err_addr <= r_base + r_rsp[12:0];
            end
        end
    end
endmodule

// File: tb/tb_sys_mem_test_master.sv
// tb_sys_mem_test_master: directed scenarios against a memory slave model with a bus scoreboard
module tb_sys_mem_test_master;
    typedef struct packed {
        logic        wr;
        logic [12:0] a;
        logic [63:0] d;
    } bus_t;
    typedef struct {
        logic [63:0] d;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [12:0] base_addr = 13'd0;
    logic [13:0] length = 14'd0;
    logic [31:0] seed = 32'd0;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [12:0] first_err_addr;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   lat = 1;
    bit   rand_wait = 1'b0;
    bit   chk_bus = 1'b1;
    int   out_n = 0;
    int   max_out = 0;
    int   done_cnt = 0;
    bus_t exp_q[$];
    rsp_t rsp_q[$];
    logic [63:0] mem [8192];

    sys_mem_test_master_if avm ();

    sys_mem_test_master #(.MAX_PENDING(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .avm            (avm)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [31:0] s, input int i);
        logic [31:0] x;
        x = s + 32'(i);
        return {x, ~x};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [12:0] b, input logic [13:0] l, input logic [31:0] s);
        int   n;
        bus_t e;
        n = (l > 14'd8192) ? 8192 : int'(l);
        if (m[0]) for (int i = 0; i < n; i++) begin
            e.wr = 1'b1; e.a = b + 13'(i); e.d = pat(s, i);
            exp_q.push_back(e);
        end
        if (m[1]) for (int i = 0; i < n; i++) begin
            e.wr = 1'b0; e.a = b + 13'(i); e.d = 64'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [12:0] b, input logic [13:0] l, input logic [31:0] s);
        @(negedge clk);
        mode = m; base_addr = b; length = l; seed = s; start = 1'b1;
        done_cnt = 0; max_out = 0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'(1));
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
        chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
        chk({tag, "_bus_all_seen"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run(input logic [1:0] m, input logic [12:0] b, input logic [13:0] l, input logic [31:0] s, input string tag);
        push_exp(m, b, l, s);
        pulse_start(m, b, l, s);
        wait_done(tag);
    endtask

    // Mismatches the check pass should find, from the bench's own memory image
    task automatic model_errs(input logic [12:0] b, input int n, input logic [31:0] s, output int cnt, output logic [12:0] fa);
        cnt = 0; fa = 13'd0;
        for (int i = 0; i < n; i++) if (mem[13'(b + 13'(i))] !== pat(s, i)) begin
            if (cnt == 0) fa = b + 13'(i);
            cnt++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    // Memory slave: decides waitrequest and returns in-order responses after a fixed latency
    initial begin
        bus_t        e;
        rsp_t        r;
        logic [12:0] sa;
        logic [63:0] sd;
        logic [1:0]  srw;
        bit          stalled;
        stalled = 1'b0;
        sa = '0; sd = '0; srw = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 64'd0;
        avm.avm_waitrequest = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata = 64'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                avm.avm_readdatavalid = 1'b1;
                avm.avm_readdata = r.d;
                out_n--;
            end else begin
                avm.avm_readdatavalid = 1'b0;
                avm.avm_readdata = 64'd0;
            end
            if (stalled) begin
                chk("stall_addr", 64'(avm.avm_address), 64'(sa));
                chk("stall_data", avm.avm_writedata, sd);
                chk("stall_rw", 64'({avm.avm_read, avm.avm_write}), 64'(srw));
            end
            if (avm.avm_read || avm.avm_write) chk("rd_wr_exclusive", 64'(avm.avm_read & avm.avm_write), 64'(0));
            avm.avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            stalled = (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
            sa = avm.avm_address; sd = avm.avm_writedata; srw = {avm.avm_read, avm.avm_write};
            if ((avm.avm_read || avm.avm_write) && !avm.avm_waitrequest) begin
                if (chk_bus) begin
                    chk("cmd_expected", 64'(exp_q.size() != 0), 64'(1));
                    chk("byteenable", 64'(avm.avm_byteenable), 64'hFF);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("cmd_kind", 64'(avm.avm_write), 64'(e.wr));
                        chk("cmd_addr", 64'(avm.avm_address), 64'(e.a));
                        if (e.wr) chk("wdata", avm.avm_writedata, e.d);
                    end
                end
                if (avm.avm_write) mem[avm.avm_address] = avm.avm_writedata;
                else begin
                    r.d = mem[avm.avm_address];
                    r.due = cyc + lat;
                    rsp_q.push_back(r);
                    out_n++;
                    if (out_n > max_out) max_out = out_n;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int          ecnt;
        logic [12:0] efa;
        logic [31:0] s;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_read", 64'(avm.avm_read), 64'(0));
        chk("rst_write", 64'(avm.avm_write), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        chk("rst_first", 64'(first_err_addr), 64'(0));
        chk("rst_addr", 64'(avm.avm_address), 64'(0));
        chk("rst_wdata", avm.avm_writedata, 64'(0));
        reset = 1'b0;

        run(2'b11, 13'd0, 14'd16, 32'h0000_1000, "fill_check");
        chk("fill_check_err", 64'(err_count), 64'(0));
        chk("fill_check_first", 64'(first_err_addr), 64'(0));

        s = $urandom;
        run(2'b11, 13'd8190, 14'd4, s, "wrap");
        chk("wrap_err", 64'(err_count), 64'(0));

        run(2'b01, 13'd100, 14'd16, 32'hCAFE_0000, "corrupt_fill");
        mem[105] = mem[105] ^ 64'h1;
        run(2'b10, 13'd100, 14'd16, 32'hCAFE_0000, "corrupt_check");
        chk("corrupt_err", 64'(err_count), 64'(1));
        chk("corrupt_first", 64'(first_err_addr), 64'(105));
        repeat (5) @(negedge clk);
        chk("corrupt_err_hold", 64'(err_count), 64'(1));
        chk("corrupt_first_hold", 64'(first_err_addr), 64'(105));

        lat = 8;
        run(2'b11, 13'd500, 14'd32, 32'h1234_5678, "lat8");
        chk("lat8_err", 64'(err_count), 64'(0));
        chk("lat8_max_pending", 64'(max_out), 64'(4));

        lat = 3;
        rand_wait = 1'b1;
        run(2'b11, 13'd1000, 14'd24, $urandom, "randwait");
        chk("randwait_err", 64'(err_count), 64'(0));
        rand_wait = 1'b0;
        lat = 1;

        run(2'b11, 13'd50, 14'd0, 32'd7, "len0");
        run(2'b00, 13'd50, 14'd8, 32'd7, "mode0");

        s = 32'hF00D_0000;
        run(2'b01, 13'd4000, 14'd16383, s, "clamp_fill");
        run(2'b10, 13'd4000, 14'd16, s, "clamp_check");
        chk("clamp_check_err", 64'(err_count), 64'(0));
        model_errs(13'd4000, 16, s + 32'd1, ecnt, efa);
        run(2'b10, 13'd4000, 14'd16, s + 32'd1, "all_bad");
        chk("all_bad_err", 64'(err_count), 64'(ecnt));
        chk("all_bad_first", 64'(first_err_addr), 64'(efa));

        push_exp(2'b11, 13'd300, 14'd8, 32'hABCD);
        pulse_start(2'b11, 13'd300, 14'd8, 32'hABCD);
        mode = 2'b01; base_addr = 13'd0; length = 14'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_while_busy");
        chk("start_while_busy_err", 64'(err_count), 64'(0));

        chk_bus = 1'b0;
        pulse_start(2'b11, 13'd200, 14'd64, 32'h55);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_third_write", 64'(avm.avm_write), 64'(1));
        chk("rst_mid_third_addr", 64'(avm.avm_address), 64'(202));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_write_off", 64'(avm.avm_write), 64'(0));
        chk("rst_mid_read_off", 64'(avm.avm_read), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_quiet", 64'({avm.avm_read, avm.avm_write}), 64'(0));
        chk_bus = 1'b1;
        run(2'b11, 13'd7000, 14'd2, 32'h9999_0000, "after_reset");
        chk("after_reset_err", 64'(err_count), 64'(0));
        chk("after_reset_first", 64'(first_err_addr), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
